// File: rtl/ahb_si_arbiter_rr.sv
// Round-robin arbiter for one AHB slave-interface port.
// Drives a one-hot address-phase grant (addr_sel) and the matching
// data-phase select (data_sel), which lags addr_sel by one accepted
// address phase. Bursts (SEQ/BUSY) and locked sequences are never broken.

// Select-vector integrity checker, kept apart from the arbiter logic.
module ahb_si_arbiter_rr_chk #(
  parameter int CHANNEL_NUM = 7
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  input logic [CHANNEL_NUM-1:0] addr_sel_i,
  input logic [CHANNEL_NUM-1:0] data_sel_i
);
  a_addr_sel_onehot0: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(addr_sel_i));
  a_data_sel_onehot0: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(data_sel_i));
endmodule

module ahb_si_arbiter_rr #(
  parameter int CHANNEL_NUM = 7,
  parameter int MAX_HOLD    = 16,
  parameter int CNT_W       = 5
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [CHANNEL_NUM-1:0]         req,
  input  logic [2*CHANNEL_NUM-1:0]       htrans,
  input  logic [CHANNEL_NUM-1:0]         hmastlock,
  input  logic                           hready,
  output logic [CHANNEL_NUM-1:0]         addr_sel,
  output logic [CHANNEL_NUM-1:0]         data_sel,
  output logic [$clog2(CHANNEL_NUM)-1:0] owner_id,
  output logic                           owner_valid
);
  localparam int IDW = $clog2(CHANNEL_NUM);
  localparam logic [1:0]             HT_IDLE   = 2'b00;
  localparam logic [1:0]             HT_NONSEQ = 2'b10;
  localparam logic [CNT_W-1:0]       CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]       HOLD_LIM  = CNT_W'(MAX_HOLD);
  localparam logic [CHANNEL_NUM-1:0] SEL_ONE   = CHANNEL_NUM'(1);
  localparam logic [IDW-1:0]         PTR_RST   = IDW'(CHANNEL_NUM - 1);

  typedef enum logic {FREE = 1'b0, OWNED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
  logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [IDW-1:0] own_idx_s;
  logic [1:0]     own_trans_s;
  logic           own_req_s;
  logic           own_lock_s;
  logic           hold_hit_s;
  logic           arb_s;
  logic           win_found_s;
  logic [IDW-1:0] win_idx_s;

  // Index reached by stepping 'step' places past 'base', wrapping at CHANNEL_NUM.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    return IDW'(sum % CHANNEL_NUM);
  endfunction

  // Decode the one-hot grant register into the owner's binary index (0 when free).
  always_comb begin
    own_idx_s = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      own_idx_s = own_idx_s | (addr_sel_q[i] ? IDW'(i) : '0);
    end
  end

  assign own_trans_s = htrans[{own_idx_s, 1'b0} +: 2];
  assign own_req_s   = req[own_idx_s];
  assign own_lock_s  = hmastlock[own_idx_s];
  assign hold_hit_s  = (MAX_HOLD != 0) && (cnt_q >= HOLD_LIM);

  // Round-robin search from pointer+1; the current owner (at the pointer) comes last.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = ptr_q;
    for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
      if (!win_found_s && req[rr_idx(ptr_q, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_idx(ptr_q, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Decide whether this accepted edge may re-arbitrate; locks and bursts block it.
  always_comb begin
    arb_s = 1'b1;
    case (state_q)
      FREE: arb_s = 1'b1;
      OWNED: begin
        if (own_lock_s) begin
          arb_s = 1'b0;
        end else begin
          arb_s = !own_req_s || (own_trans_s == HT_IDLE) ||
                  ((own_trans_s == HT_NONSEQ) && hold_hit_s);
        end
      end
      default: arb_s = 1'b1;
    endcase
  end

  // Next-state for FSM, selects, pointer and hold counter; all frozen while hready=0.
  always_comb begin
    state_d    = state_q;
    addr_sel_d = addr_sel_q;
    data_sel_d = data_sel_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    if (hready) begin
      data_sel_d = addr_sel_q;
      if (arb_s) begin
        cnt_d = '0;
        if (win_found_s) begin
          state_d    = OWNED;
          addr_sel_d = SEL_ONE << win_idx_s;
          ptr_d      = win_idx_s;
        end else begin
          state_d    = FREE;
          addr_sel_d = '0;
        end
      end else if ((own_trans_s == HT_NONSEQ) && (cnt_q != CNT_SAT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= FREE;
      addr_sel_q <= '0;
      data_sel_q <= '0;
      ptr_q      <= PTR_RST;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_sel_q <= addr_sel_d;
      data_sel_q <= data_sel_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign addr_sel    = addr_sel_q;
  assign data_sel    = data_sel_q;
  assign owner_id    = own_idx_s;
  assign owner_valid = |addr_sel_q;

  ahb_si_arbiter_rr_chk #(.CHANNEL_NUM(CHANNEL_NUM)) u_chk (
    .clk_i      (HCLK),
    .rst_n_i    (HRESETn),
    .addr_sel_i (addr_sel_q),
    .data_sel_i (data_sel_q)
  );

endmodule
